// File: rtl/approx5_subtractor_pipe.sv
// Two-stage approximate subtractor: diff = a + ~b with the low K bits replaced by ~b
// and a[K-1] used as the carry into the precise part. Valid/ready on both sides.
module approx5_subtractor_pipe #(
  parameter int ADDER_LENGTH   = 32,
  parameter int IMPRECISE_PART = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDER_LENGTH-1:0] a,
  input  logic [ADDER_LENGTH-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDER_LENGTH-1:0] diff,
  output logic                    borrow
);
  localparam int N     = ADDER_LENGTH;
  localparam int K     = IMPRECISE_PART;
  localparam int SPLIT = (N + K) / 2;
  localparam int MW    = SPLIT - K;
  localparam int HW    = N - SPLIT;

  logic            v1_q, v2_q;
  logic [SPLIT-1:0] lo_q, lo_d;
  logic            c1_q, c1_d;
  logic [HW-1:0]   a_hi_q, nb_hi_q;
  logic [N-1:0]    diff_q, diff_d;
  logic            borrow_q, borrow_d;

  logic [MW:0]     mid_sum;
  logic [HW:0]     hi_sum;
  logic            adv1, adv2, accept;

  assign adv2     = ~v2_q | out_ready;
  assign adv1     = ~v1_q | adv2;
  assign accept   = in_valid & adv1;
  assign in_ready = adv1;

  // The two's-complement +1 is dropped; a[K-1] stands in as the carry into bit K.
  always_comb begin
    mid_sum = {1'b0, a[SPLIT-1:K]} + {1'b0, ~b[SPLIT-1:K]} + {{MW{1'b0}}, a[K-1]};
    lo_d    = {mid_sum[MW-1:0], ~b[K-1:0]};
    c1_d    = mid_sum[MW];
  end

  always_comb begin
    hi_sum   = {1'b0, a_hi_q} + {1'b0, nb_hi_q} + {{HW{1'b0}}, c1_q};
    diff_d   = {hi_sum[HW-1:0], lo_q};
    borrow_d = ~hi_sum[HW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      lo_q     <= '0;
      c1_q     <= 1'b0;
      a_hi_q   <= '0;
      nb_hi_q  <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          diff_q   <= diff_d;
          borrow_q <= borrow_d;
        end
      end
      if (adv1) begin
        v1_q <= accept;
        if (accept) begin
          lo_q    <= lo_d;
          c1_q    <= c1_d;
          a_hi_q  <= a[N-1:SPLIT];
          nb_hi_q <= ~b[N-1:SPLIT];
        end
      end
    end
  end

  assign out_valid = v2_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
endmodule

// File: tb/tb_approx5_subtractor_pipe.sv
// Directed bench for approx5_subtractor_pipe (N=32, K=16): hand vectors, streaming,
// backpressure and async reset.
module tb_approx5_subtractor_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0, b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] diff;
  logic        borrow;

  int errs = 0;
  int checks = 0;

  approx5_subtractor_pipe #(.ADDER_LENGTH(32), .IMPRECISE_PART(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: {borrow, diff}
  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y);
    logic [16:0] hi;
    hi = {1'b0, x[31:16]} + {1'b0, ~y[31:16]} + {16'd0, x[15]};
    return {~hi[16], hi[15:0], ~y[15:0]};
  endfunction

  task automatic single(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ed, input logic eb);
    a = x; b = y; in_valid = 1'b1;
    chk({tag, "_rdy"}, in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk({tag, "_v1"}, out_valid, 1'b0);
    step();
    chk({tag, "_v2"}, out_valid, 1'b1);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_borrow"}, borrow, eb);
    step();
  endtask

  logic [31:0] pa [8];
  logic [31:0] pb [8];
  logic [32:0] expq [$];
  logic [32:0] e;
  int acc, got;

  initial begin
    #3;
    chk("rst_ovalid", out_valid, 1'b0);
    chk("rst_diff", diff, 32'h0);
    chk("rst_borrow", borrow, 1'b0);
    chk("rst_inrdy", in_ready, 1'b1);
    step(); step();
    rst = 1'b0;

    single("t1", 32'h0005_0000, 32'h0001_0000, 32'h0003_FFFF, 1'b0);
    single("t2", 32'h0000_8000, 32'h0000_0000, 32'h0000_FFFF, 1'b0);
    single("t3", 32'h0000_0000, 32'h0001_0000, 32'hFFFE_FFFF, 1'b1);
    single("aeqb", 32'h1234_5678, 32'h1234_5678, 32'hFFFF_A987, 1'b1);
    single("wrap", 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);

    // Streaming: accept on edge j, result visible after edge j+1.
    for (int i = 0; i < 8; i++) begin
      pa[i] = $urandom; pb[i] = $urandom;
    end
    out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      in_valid = (j < 8);
      if (j < 8) begin a = pa[j]; b = pb[j]; end
      step();
      chk($sformatf("strm_v%0d", j), out_valid, (j >= 1 && j <= 8));
      if (j >= 1 && j <= 8) begin
        e = model(pa[j-1], pb[j-1]);
        chk($sformatf("strm_d%0d", j - 1), {borrow, diff}, e);
      end
    end
    in_valid = 1'b0;
    step();

    // Backpressure: hold out_ready low; offer a new pair only after each accept.
    for (int i = 0; i < 5; i++) begin
      pa[i] = $urandom; pb[i] = $urandom;
    end
    out_ready = 1'b0;
    acc = 0;
    expq.delete();
    for (int j = 0; j < 5; j++) begin
      in_valid = 1'b1; a = pa[acc]; b = pb[acc];
      #1;
      if (in_ready) begin
        expq.push_back(model(pa[acc], pb[acc]));
        acc++;
      end
      step();
      if (out_valid) chk($sformatf("stall_hold%0d", j), {borrow, diff}, model(pa[0], pb[0]));
    end
    chk("stall_accepts", acc, 2);
    chk("stall_inrdy", in_ready, 1'b0);
    chk("stall_ovalid", out_valid, 1'b1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    got = 0;
    for (int j = 0; j < 6; j++) begin
      if (out_valid) begin
        if (expq.size() == 0) chk("drain_extra", 1'b1, 1'b0);
        else begin
          e = expq.pop_front();
          chk($sformatf("drain%0d", got), {borrow, diff}, e);
        end
        got++;
      end
      step();
    end
    chk("drain_count", got, 2);

    // Async reset with both stages full.
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'h0005_0000; b = 32'h0001_0000;
    step();
    a = 32'h0000_8000; b = 32'h0;
    step();
    in_valid = 1'b0;
    chk("pre_rst_ovalid", out_valid, 1'b1);
    chk("pre_rst_inrdy", in_ready, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("arst_ovalid", out_valid, 1'b0);
    chk("arst_diff", diff, 32'h0);
    chk("arst_borrow", borrow, 1'b0);
    chk("arst_inrdy", in_ready, 1'b1);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step();
      chk($sformatf("post_rst_v%0d", j), out_valid, 1'b0);
    end
    single("after_rst", 32'h0000_0000, 32'h0001_0000, 32'hFFFE_FFFF, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
